// File: rtl/ifid_pipe_buffer.sv
// ifid_pipe_buffer - IF/ID pipeline buffer.
//
// Small circular FIFO of {addr, instr} pairs between fetch and decode, with
// valid/ready handshakes on both sides. Stalls are handled by back-pressure,
// and flush drops everything on a branch redirect. The head entry is also
// sliced into opcode/rd1/rd2/funct/offset for decode and the forwarding unit.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   flush            drop all entries (redirect); beats push and pop
//   if_valid/if_ready, instr_in, addr_in   fetch-side handshake and payload
//   id_valid/id_ready, instr_out, addr_out decode-side handshake and payload
//   opcode, rd1, rd2, funct, offset        field slices of instr_out
//   count            current occupancy
//   stall_cnt        (only with IFID_STALL_CNT_EN) saturating count of stall
//                    cycles; cleared by rst only, not by flush
//
// Optional feature macro: IFID_STALL_CNT_EN
module ifid_pipe_buffer #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned FIELD_W = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [INSTR_W-1:0]           instr_in,
  input  logic [ADDR_W-1:0]            addr_in,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [INSTR_W-1:0]           instr_out,
  output logic [ADDR_W-1:0]            addr_out,
  output logic [FIELD_W-1:0]           opcode,
  output logic [FIELD_W-1:0]           rd1,
  output logic [FIELD_W-1:0]           rd2,
  output logic [FIELD_W-1:0]           funct,
  output logic [INSTR_W-FIELD_W-1:0]   offset,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  addr_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic full, empty, push, pop;

  // Handshake flags come from registered occupancy only.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign if_ready = !full;
  assign id_valid = !empty;
  assign count    = count_q;

  assign push = if_valid && !full  && !flush;
  assign pop  = id_ready && !empty && !flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem_q[wr_ptr_q] <= instr_in;
      addr_mem_q[wr_ptr_q]  <= addr_in;
    end
  end

  // Empty buffer presents an all-zero bubble (opcode 0 = NOP).
  assign instr_out = empty ? '0 : instr_mem_q[rd_ptr_q];
  assign addr_out  = empty ? '0 : addr_mem_q[rd_ptr_q];

  assign opcode = instr_out[INSTR_W-1 -: FIELD_W];
  assign rd1    = instr_out[INSTR_W-FIELD_W-1 -: FIELD_W];
  assign rd2    = instr_out[INSTR_W-2*FIELD_W-1 -: FIELD_W];
  assign funct  = instr_out[FIELD_W-1:0];
  assign offset = instr_out[INSTR_W-FIELD_W-1:0];

`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  assign stall = (id_valid && !id_ready) || (if_valid && !if_ready);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_pipe_buffer.sv
module tb_ifid_pipe_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, id_ready;
  logic        if_ready, id_valid;
  logic [15:0] instr_in, instr_out;
  logic [7:0]  addr_in, addr_out;
  logic [3:0]  opcode, rd1, rd2, funct;
  logic [11:0] offset;
  logic [1:0]  count;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ifid_pipe_buffer #(.INSTR_W(16), .ADDR_W(8), .FIELD_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .instr_in(instr_in), .addr_in(addr_in),
    .id_valid(id_valid), .id_ready(id_ready),
    .instr_out(instr_out), .addr_out(addr_out),
    .opcode(opcode), .rd1(rd1), .rd2(rd2), .funct(funct), .offset(offset),
    .count(count)
`ifdef IFID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so checks and new drives
  // sit well away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_id_valid"}, 32'(id_valid), 32'h0);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'h1);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_instr"}, 32'(instr_out), 32'h0);
    chk({tag, "_addr"}, 32'(addr_out), 32'h0);
    chk({tag, "_opcode"}, 32'(opcode), 32'h0);
    chk({tag, "_offset"}, 32'(offset), 32'h0);
  endtask

  logic [15:0] q_instr[$];
  logic [7:0]  q_addr[$];
  logic [15:0] next_instr;

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    instr_in = '0; addr_in = '0;
    step();
    step();
    chk_bubble("reset");

    // Single push and field decode.
    rst = 1'b0;
    if_valid = 1'b1; instr_in = 16'h1234; addr_in = 8'h10;
    #1 chk("no_passthru", 32'(id_valid), 32'h0);
    step();
    if_valid = 1'b0;
    chk("dec_id_valid", 32'(id_valid), 32'h1);
    chk("dec_opcode", 32'(opcode), 32'h1);
    chk("dec_rd1", 32'(rd1), 32'h2);
    chk("dec_rd2", 32'(rd2), 32'h3);
    chk("dec_funct", 32'(funct), 32'h4);
    chk("dec_offset", 32'(offset), 32'h234);
    chk("dec_addr", 32'(addr_out), 32'h10);
    chk("dec_count", 32'(count), 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("clr_count", 32'(count), 32'h0);

    // Fill to full, overflow attempt ignored, drain in order.
    if_valid = 1'b1; instr_in = 16'hA001; addr_in = 8'h20;
    step();
    instr_in = 16'hB002; addr_in = 8'h21;
    step();
    chk("full_if_ready", 32'(if_ready), 32'h0);
    chk("full_count", 32'(count), 32'h2);
    chk("full_head", 32'(instr_out), 32'hA001);
    instr_in = 16'hC003; addr_in = 8'h22;
    step();
    chk("ovf_count", 32'(count), 32'h2);
    chk("ovf_head", 32'(instr_out), 32'hA001);
    if_valid = 1'b0; id_ready = 1'b1;
    step();
    chk("pop1_instr", 32'(instr_out), 32'hB002);
    chk("pop1_addr", 32'(addr_out), 32'h21);
    chk("pop1_count", 32'(count), 32'h1);
    step();
    chk("pop2_id_valid", 32'(id_valid), 32'h0);
    chk("pop2_instr", 32'(instr_out), 32'h0);

    // Full buffer, push and pop offered together; queue model predicts.
    id_ready = 1'b0; if_valid = 1'b1;
    instr_in = 16'hE000; addr_in = 8'h40;
    step();
    q_instr.push_back(16'hE000); q_addr.push_back(8'h40);
    instr_in = 16'hE001; addr_in = 8'h41;
    step();
    q_instr.push_back(16'hE001); q_addr.push_back(8'h41);
    chk("wrap_fill_count", 32'(count), 32'h2);
    next_instr = 16'hE002;
    instr_in = next_instr; addr_in = 8'h42;
    id_ready = 1'b1;
    for (int unsigned c = 0; c < 6; c++) begin
      automatic bit do_push = (q_instr.size() < 2);
      automatic bit do_pop  = (q_instr.size() > 0);
      step();
      if (do_pop) begin
        void'(q_instr.pop_front());
        void'(q_addr.pop_front());
      end
      if (do_push) begin
        q_instr.push_back(instr_in); q_addr.push_back(addr_in);
        next_instr = next_instr + 16'd1;
        instr_in = next_instr; addr_in = addr_in + 8'd1;
      end
      chk("wrap_count", 32'(count), 32'(q_instr.size()));
      chk("wrap_instr", 32'(instr_out), (q_instr.size() > 0) ? 32'(q_instr[0]) : 32'h0);
      chk("wrap_addr", 32'(addr_out), (q_addr.size() > 0) ? 32'(q_addr[0]) : 32'h0);
    end

    // Make sure two entries are held, then flush with a push offered.
    id_ready = 1'b0;
    step();
    step();
    chk("pre_flush_count", 32'(count), 32'h2);
    flush = 1'b1; instr_in = 16'hD00D; addr_in = 8'h55;
    step();
    flush = 1'b0;
    chk_bubble("flush");
    if_valid = 1'b0;
    step();
    chk("flush_drop_valid", 32'(id_valid), 32'h0);
    q_instr.delete(); q_addr.delete();

    // Streaming, then a one-cycle reset mid-transfer.
    if_valid = 1'b1; id_ready = 1'b1;
    instr_in = 16'h5000; addr_in = 8'h60;
    step();
    instr_in = 16'h5001; addr_in = 8'h61;
    step();
    chk("stream_instr", 32'(instr_out), 32'h5001);
    chk("stream_count", 32'(count), 32'h1);
    rst = 1'b1; instr_in = 16'h5002; addr_in = 8'h62;
    step();
    rst = 1'b0;
    chk_bubble("midrst");
    instr_in = 16'h6001; addr_in = 8'h70;
    step();
    chk("resume_valid", 32'(id_valid), 32'h1);
    chk("resume_instr", 32'(instr_out), 32'h6001);
    chk("resume_addr", 32'(addr_out), 32'h70);

`ifdef IFID_STALL_CNT_EN
    if_valid = 1'b0; id_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stall_rst", 32'(stall_cnt), 32'h0);
    if_valid = 1'b1; instr_in = 16'h7777; addr_in = 8'h01;
    step();
    if_valid = 1'b0;
    for (int unsigned c = 0; c < 5; c++) step();
    chk("stall_five", 32'(stall_cnt), 32'h5);
    // id_ready high so the flush cycle itself is not a stall cycle.
    flush = 1'b1; id_ready = 1'b1;
    step();
    flush = 1'b0; id_ready = 1'b0;
    chk("stall_flush", 32'(stall_cnt), 32'h5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stall_clr", 32'(stall_cnt), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule
